step_sequencer: RTL and testbench
=================================

# step_sequencer

Downstream stage of the motion-profile step generator: consumes its raw step clock, counts out a commanded signed number of steps, and drives the external stepper driver's STEP/DIR pins with guaranteed DIR setup time and minimum STEP high/low widths. Runs in the 1 MHz int_clk domain, so one cycle is 1 us. It gates the profile generator through enable_o, tracks absolute position, and reports completion.

## Interface
- DIR_SETUP, 2, int_clk cycles DIR must be stable before the first STEP rise (min 1)
- PULSE_HIGH, 2, STEP high width in cycles (min 1)
- PULSE_LOW, 2, minimum STEP low width in cycles after each pulse (min 1)
- int_clk  input  1  1 MHz block clock
- reset_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  one-cycle command strobe, honoured only in IDLE
- target_steps_i  input  32  signed two's-complement relative step count, sampled on start_i
- abort_i  input  1  level; stops the move at the next safe point
- step_req_i  input  1  raw step clock from the profile generator, asynchronous to int_clk
- enable_o  output  1  enable to the profile generator
- step_o  output  1  STEP to the driver
- dir_o  output  1  DIR to the driver; 1 = positive
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse on normal completion
- overrun_o  output  1  sticky; a step request was lost
- position_o  output  32  signed absolute position in steps

## Operation
- Reset is asynchronous and active-low on reset_n_i; the clock is int_clk. Every output resets to 0, the state to IDLE, and the synchronizer and internal counters to 0.
- step_req_i passes through a 2-FF synchronizer. A rising edge is detected on the synchronized copy.
- States and transitions:
  - IDLE. On start_i, latch dir = ~target[31] and remaining = |target| as a 32-bit unsigned value, so -2^31 gives 2^31. If remaining = 0, go to DONE. Otherwise load dir_o and go to SETUP.
  - SETUP. Count DIR_SETUP cycles, then assert enable_o and go to WAIT.
  - WAIT. On a detected edge, go to HIGH.
  - HIGH. On entry, raise step_o, decrement remaining, and step position_o by ±1 according to dir. Hold for PULSE_HIGH cycles, then go to LOW.
  - LOW. step_o = 0 for at least PULSE_LOW cycles. When they expire:
    - remaining = 0: go to DONE.
    - pending flag set: clear it and go to HIGH.
    - otherwise: go to WAIT.
  - DONE. Pulse done_o for one cycle, then go to IDLE.
- enable_o drops in the same cycle that remaining is decremented to 0. No further edges are requested after the last step.
- An edge detected during HIGH or LOW sets the one-deep pending flag. If an edge arrives while the flag is already set, set overrun_o; the step is lost and not replayed.
- overrun_o clears only on reset or on an accepted start_i.
- abort_i:
  - In SETUP or WAIT: clear enable_o and go to IDLE immediately.
  - In HIGH or LOW: clear enable_o, never truncate the current pulse, finish LOW, then go to IDLE.
  - No done_o is generated, and position_o keeps the steps actually issued.
- start_i is ignored while busy_o = 1. If start_i and abort_i are both high in IDLE, abort wins and start is ignored.
- position_o wraps modulo 2^32.

## Timing
- start_i is sampled at edge N. At N+1: busy_o = 1 and dir_o is valid. enable_o rises at N+1+DIR_SETUP.
- If step_req_i rises before edge M, step_o rises at M+3: 2 synchronizer cycles plus 1 registered output.
- step_o is registered and glitch-free. Pulse period is at least PULSE_HIGH+PULSE_LOW cycles, which sets the maximum step rate to 250 kHz at defaults.
- done_o is high for the single cycle after LOW expires with remaining = 0. busy_o falls one cycle after that.
- A zero-length move gives: busy_o high for 1 cycle, done_o in the next cycle, and no step_o pulse.
- dir_o changes only on the cycle after an accepted start_i.

## Test plan
- Reset mid-pulse:
  - Stimulus: assert reset_n_i low while step_o = 1.
  - Required response: all outputs read 0 within the same cycle; after release the block is in IDLE and ignores step_req_i.
- Positive move:
  - Stimulus: target = 5; step_req_i period 10 us.
  - Required response: exactly 5 pulses, each high exactly 2 cycles; dir_o = 1 at least 2 cycles before the first rise; position_o goes 0 to 5; enable_o falls at the 5th rise; one done_o.
- Negative and extreme targets:
  - Stimulus: target = -3.
  - Required response: dir_o = 0 and position_o ends at -3.
  - Stimulus: target = 0.
  - Required response: done_o two cycles after start_i with no step.
  - Stimulus: target = 0x80000000.
  - Required response: latched remaining = 2^31.
- Overrun:
  - Stimulus: step_req_i at a 2 us period.
  - Required response: pending flag absorbs one edge; the next edge sets overrun_o; pulse widths are never below 2/2.
- Abort:
  - Stimulus: assert abort_i during HIGH of pulse 3 of 10.
  - Required response: pulse 3 completes with full width; no 4th pulse; no done_o; position_o = 3; busy_o falls after LOW.
- Start while busy:
  - Stimulus: a second start_i with target = 7 during a 5-step move.
  - Required response: ignored; the move ends with position_o = 5.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Command/driver bundle for step_sequencer.
// slave  : the sequencer itself (takes commands and the raw step clock, drives STEP/DIR/status).
// master : whoever issues moves and observes status.
//   start_i, target_steps_i, abort_i : move command
//   step_req_i                       : raw step clock from the profile generator (async)
//   enable_o                         : gate back to the profile generator
//   step_o, dir_o                    : driver pins
//   busy_o, done_o, overrun_o        : status
//   position_o                       : signed absolute position
interface step_sequencer_if;
  logic        start_i;
  logic [31:0] target_steps_i;
  logic        abort_i;
  logic        step_req_i;
  logic        enable_o;
  logic        step_o;
  logic        dir_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;
  logic [31:0] position_o;

  modport slave (
    input  start_i, target_steps_i, abort_i, step_req_i,
    output enable_o, step_o, dir_o, busy_o, done_o, overrun_o, position_o
  );

  modport master (
    output start_i, target_steps_i, abort_i, step_req_i,
    input  enable_o, step_o, dir_o, busy_o, done_o, overrun_o, position_o
  );
endinterface

// File: rtl/step_sequencer.sv
// STEP/DIR pulse sequencer between the motion-profile generator and the stepper driver.
// Counts out a signed relative move, enforces DIR setup and STEP high/low widths, keeps
// absolute position and flags lost step requests.
// Ports:
//   int_clk   : 1 MHz block clock
//   reset_n_i : asynchronous active-low reset
//   bus_io    : step_sequencer_if.slave (command, raw step clock, driver pins, status)
// All outputs are flops fed from the current state, so they trail the state register by one
// cycle; every output therefore lines up with the state it describes and is glitch-free.
module step_sequencer #(
  parameter int unsigned DIR_SETUP  = 2,
  parameter int unsigned PULSE_HIGH = 2,
  parameter int unsigned PULSE_LOW  = 2
) (
  input logic             int_clk,
  input logic             reset_n_i,
  step_sequencer_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StSetup, StWait, StHigh, StLow, StDone} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] pos_q, pos_d;
  logic        dir_lat_q, dir_lat_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        abort_seen_q, abort_seen_d;

  logic        enable_q, enable_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] position_q, position_d;

  logic        req_edge;
  logic        start_ok;
  logic        enter_high;
  logic [31:0] target_mag;

  assign req_edge   = sync2_q & ~sync3_q;
  // Abort beats start when both arrive in IDLE.
  assign start_ok   = (state_q == StIdle) && bus_io.start_i && !bus_io.abort_i;
  // -2^31 negates to itself, which read unsigned is the required 2^31.
  assign target_mag = bus_io.target_steps_i[31] ? (~bus_io.target_steps_i + 32'd1)
                                                : bus_io.target_steps_i;
  assign enter_high = (state_d == StHigh) && (state_q != StHigh);

  // State register plus datapath and output flops.
  always_ff @(posedge int_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      cnt_q        <= '0;
      remaining_q  <= '0;
      pos_q        <= '0;
      dir_lat_q    <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      abort_seen_q <= 1'b0;
      enable_q     <= 1'b0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      position_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus_io.step_req_i;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      cnt_q        <= cnt_d;
      remaining_q  <= remaining_d;
      pos_q        <= pos_d;
      dir_lat_q    <= dir_lat_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      abort_seen_q <= abort_seen_d;
      enable_q     <= enable_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      position_q   <= position_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = (target_mag == 32'd0) ? StDone : StSetup;
      end
      StSetup: begin
        if (bus_io.abort_i)                state_d = StIdle;
        else if (cnt_q == DIR_SETUP - 1)   state_d = StWait;
      end
      StWait: begin
        if (bus_io.abort_i) state_d = StIdle;
        else if (req_edge)  state_d = StHigh;
      end
      StHigh: begin
        if (cnt_q == PULSE_HIGH - 1) state_d = StLow;
      end
      StLow: begin
        if (cnt_q == PULSE_LOW - 1) begin
          if (abort_seen_q || bus_io.abort_i) state_d = StIdle;
          else if (remaining_q == 32'd0)      state_d = StDone;
          else if (pending_q || req_edge)     state_d = StHigh;
          else                                state_d = StWait;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: timers, step bookkeeping, pending/overrun tracking.
  always_comb begin
    cnt_d        = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    remaining_d  = remaining_q;
    pos_d        = pos_q;
    dir_lat_d    = dir_lat_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    abort_seen_d = abort_seen_q;

    if (start_ok) begin
      remaining_d  = target_mag;
      pending_d    = 1'b0;
      overrun_d    = 1'b0;
      abort_seen_d = 1'b0;
      if (target_mag != 32'd0) dir_lat_d = ~bus_io.target_steps_i[31];
    end

    if (enter_high) begin
      remaining_d = remaining_q - 32'd1;
      pos_d       = dir_lat_q ? pos_q + 32'd1 : pos_q - 32'd1;
    end

    if ((state_q == StHigh) || (state_q == StLow)) begin
      if (req_edge) begin
        // One-deep buffer; a second edge while it is full is dropped for good.
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end
      if (bus_io.abort_i) abort_seen_d = 1'b1;
    end

    // Any step taken straight out of LOW consumes the buffered (or coincident) edge.
    if ((state_q == StLow) && (state_d == StHigh)) pending_d = 1'b0;

    if (state_d == StIdle) begin
      pending_d    = 1'b0;
      abort_seen_d = 1'b0;
    end
  end

  // Output logic, registered one cycle behind the state.
  always_comb begin
    busy_d     = (state_q != StIdle);
    done_d     = (state_q == StDone);
    step_d     = (state_q == StHigh);
    dir_d      = dir_lat_q;
    position_d = pos_q;
    // remaining_q hits 0 on the cycle the last pulse starts, so enable drops with that rise.
    enable_d   = ((state_q == StWait) || (state_q == StHigh) || (state_q == StLow)) &&
                 (remaining_q != 32'd0) && !abort_seen_q && !bus_io.abort_i;
  end

  assign bus_io.enable_o   = enable_q;
  assign bus_io.step_o     = step_q;
  assign bus_io.dir_o      = dir_q;
  assign bus_io.busy_o     = busy_q;
  assign bus_io.done_o     = done_q;
  assign bus_io.overrun_o  = overrun_q;
  assign bus_io.position_o = position_q;

endmodule

// File: tb/tb_step_sequencer.sv
`timescale 1ns / 1ps
module tb_step_sequencer;

  typedef struct packed {
    logic [31:0] pos;
    logic        en;
    logic        dir;
  } exp_t;

  logic clk;
  logic rst_n;
  step_sequencer_if bus ();

  step_sequencer dut (
    .int_clk   (clk),
    .reset_n_i (rst_n),
    .bus_io    (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          base_rise;
  int          base_done;
  logic [31:0] exp_pos;
  exp_t        sb_q[$];
  logic [31:0] done_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the pulses a move should produce; the final one carries enable low and a done.
  task automatic expect_steps(input int count, input int total, input logic dir);
    for (int i = 1; i <= count; i++) begin
      exp_pos = dir ? exp_pos + 32'd1 : exp_pos - 32'd1;
      sb_q.push_back('{pos: exp_pos, en: (i != total), dir: dir});
    end
    if (count == total) done_q.push_back(exp_pos);
  endtask

  task automatic start_move(input logic [31:0] t);
    bus.target_steps_i = t;
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
  endtask

  task automatic pulse_req(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      bus.step_req_i = 1'b1;
      tick(hi);
      bus.step_req_i = 1'b0;
      tick(lo);
    end
  endtask

  task automatic wait_step();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.step_o) break;
    end
    check("step_rise_timeout", {31'd0, bus.step_o}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!bus.busy_o) break;
      tick(1);
    end
    check("busy_timeout", {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    exp_pos = 32'd0;
    sb_q.delete();
    done_q.delete();
  endtask

  // Pulse monitor: widths, scoreboard pops on each STEP rise and on each done_o.
  int   high_len = 0;
  int   low_len = 100;
  logic step_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      step_prev = 1'b0;
      high_len  = 0;
      low_len   = 100;
    end else begin
      if (bus.step_o && !step_prev) begin
        rise_cnt++;
        check("step_low_width", {31'd0, (low_len >= 2)}, 32'd1);
        if (sb_q.size() == 0) begin
          check("pulse_expected", sb_q.size(), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_position", bus.position_o, mon_e.pos);
          check("pulse_enable", {31'd0, bus.enable_o}, {31'd0, mon_e.en});
          check("pulse_dir", {31'd0, bus.dir_o}, {31'd0, mon_e.dir});
        end
        high_len = 1;
      end else if (bus.step_o) begin
        high_len++;
      end else if (step_prev) begin
        check("step_high_width", high_len, 32'd2);
        low_len = 1;
      end else if (low_len < 1000) begin
        low_len++;
      end
      step_prev = bus.step_o;
      if (bus.done_o) begin
        done_cnt++;
        if (done_q.size() == 0) check("done_expected", done_q.size(), 32'd1);
        else check("done_position", bus.position_o, done_q.pop_front());
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.start_i        = 1'b0;
    bus.target_steps_i = 32'd0;
    bus.abort_i        = 1'b0;
    bus.step_req_i     = 1'b0;
    exp_pos            = 32'd0;
    tick(2);
    check("rst_step", {31'd0, bus.step_o}, 32'd0);
    check("rst_enable", {31'd0, bus.enable_o}, 32'd0);
    check("rst_dir", {31'd0, bus.dir_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun_o}, 32'd0);
    check("rst_position", bus.position_o, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Reset while STEP is high.
    expect_steps(1, 2, 1'b1);
    start_move(32'd2);
    tick(3);
    bus.step_req_i = 1'b1;
    wait_step();
    bus.step_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_step", {31'd0, bus.step_o}, 32'd0);
    check("midrst_enable", {31'd0, bus.enable_o}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_dir", {31'd0, bus.dir_o}, 32'd0);
    check("midrst_position", bus.position_o, 32'd0);
    sb_q.delete();
    done_q.delete();
    tick(1);
    rst_n = 1'b1;
    exp_pos = 32'd0;
    tick(1);
    base_rise = rise_cnt;
    pulse_req(2, 2, 2);
    tick(4);
    check("postrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("postrst_pulses", rise_cnt - base_rise, 32'd0);

    // Positive move of 5 with DIR setup and enable timing.
    expect_steps(5, 5, 1'b1);
    base_done = done_cnt;
    start_move(32'd5);
    check("pos_busy_n", {31'd0, bus.busy_o}, 32'd0);
    tick(1);
    check("pos_busy_n1", {31'd0, bus.busy_o}, 32'd1);
    check("pos_dir_n1", {31'd0, bus.dir_o}, 32'd1);
    check("pos_enable_n1", {31'd0, bus.enable_o}, 32'd0);
    tick(1);
    check("pos_enable_n2", {31'd0, bus.enable_o}, 32'd0);
    tick(1);
    check("pos_enable_n3", {31'd0, bus.enable_o}, 32'd1);
    pulse_req(5, 5, 5);
    wait_idle(100);
    check("pos_final", bus.position_o, 32'd5);
    check("pos_done_count", done_cnt - base_done, 32'd1);
    check("pos_enable_end", {31'd0, bus.enable_o}, 32'd0);

    // -2^31 latches a magnitude of 2^31; aborted in SETUP.
    start_move(32'h8000_0000);
    check("ext_remaining", dut.remaining_q, 32'h8000_0000);
    tick(1);
    check("ext_dir", {31'd0, bus.dir_o}, 32'd0);
    check("ext_busy", {31'd0, bus.busy_o}, 32'd1);
    bus.abort_i = 1'b1;
    tick(1);
    bus.abort_i = 1'b0;
    wait_idle(20);
    check("ext_enable", {31'd0, bus.enable_o}, 32'd0);
    check("ext_position", bus.position_o, 32'd5);

    // Requests every 2 cycles: one absorbed by the pending flag, the next lost.
    expect_steps(2, 5, 1'b1);
    start_move(32'd5);
    tick(3);
    pulse_req(3, 1, 1);
    tick(8);
    check("ovr_flag", {31'd0, bus.overrun_o}, 32'd1);
    check("ovr_position", bus.position_o, 32'd7);
    bus.abort_i = 1'b1;
    tick(1);
    bus.abort_i = 1'b0;
    wait_idle(20);
    check("ovr_sticky", {31'd0, bus.overrun_o}, 32'd1);

    // Zero-length move: done with no pulse; accepted start clears overrun.
    done_q.push_back(exp_pos);
    base_rise = rise_cnt;
    start_move(32'd0);
    check("zero_overrun_clr", {31'd0, bus.overrun_o}, 32'd0);
    check("zero_done_n", {31'd0, bus.done_o}, 32'd0);
    tick(1);
    check("zero_done_n1", {31'd0, bus.done_o}, 32'd1);
    check("zero_busy_n1", {31'd0, bus.busy_o}, 32'd1);
    tick(1);
    check("zero_done_n2", {31'd0, bus.done_o}, 32'd0);
    check("zero_busy_n2", {31'd0, bus.busy_o}, 32'd0);
    check("zero_pulses", rise_cnt - base_rise, 32'd0);

    // Negative move of 3 from a fresh reset.
    reset_dut();
    expect_steps(3, 3, 1'b0);
    start_move(32'hFFFF_FFFD);
    tick(1);
    check("neg_dir", {31'd0, bus.dir_o}, 32'd0);
    tick(2);
    pulse_req(3, 5, 5);
    wait_idle(100);
    check("neg_final", bus.position_o, 32'hFFFF_FFFD);

    // Abort during HIGH of pulse 3 of 10.
    reset_dut();
    expect_steps(3, 10, 1'b1);
    base_done = done_cnt;
    start_move(32'd10);
    tick(3);
    pulse_req(2, 5, 5);
    bus.step_req_i = 1'b1;
    wait_step();
    bus.abort_i = 1'b1;
    tick(1);
    check("abort_enable", {31'd0, bus.enable_o}, 32'd0);
    check("abort_step_held", {31'd0, bus.step_o}, 32'd1);
    check("abort_busy_low_phase", {31'd0, bus.busy_o}, 32'd1);
    bus.abort_i = 1'b0;
    bus.step_req_i = 1'b0;
    tick(4);
    pulse_req(2, 5, 5);
    wait_idle(50);
    check("abort_position", bus.position_o, 32'd3);
    check("abort_no_done", done_cnt - base_done, 32'd0);

    // Second start during a 5-step move is ignored.
    reset_dut();
    expect_steps(5, 5, 1'b1);
    base_done = done_cnt;
    start_move(32'd5);
    tick(3);
    pulse_req(2, 5, 5);
    start_move(32'd7);
    pulse_req(3, 5, 5);
    wait_idle(100);
    check("busy_start_position", bus.position_o, 32'd5);
    check("busy_start_done", done_cnt - base_done, 32'd1);

    // Start and abort together in IDLE: abort wins.
    bus.abort_i = 1'b1;
    start_move(32'd3);
    bus.abort_i = 1'b0;
    tick(2);
    check("idle_abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check("idle_abort_position", bus.position_o, 32'd5);

    tick(4);
    check("sb_empty", sb_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
